// File: rtl/secure_xfer_if.sv
// Handshake bundle for the secure transfer engine.
// The write side carries reg->mem traffic, the read side mem->reg traffic.
// master: the requester/consumer side; slave: the engine.
interface secure_xfer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int KEY_W  = 16
);
    logic              wr_valid;
    logic [KEY_W-1:0]  wr_key;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              rd_valid;
    logic [KEY_W-1:0]  rd_key;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_ready;
    logic              reg_valid;
    logic [DATA_W-1:0] reg_data;
    logic              reg_ready;

    modport master (
        output wr_valid, wr_key, wr_addr, wr_data, mem_ready,
        output rd_valid, rd_key, rd_addr, rd_data, reg_ready,
        input  wr_ready, mem_valid, mem_data,
        input  rd_ready, reg_valid, reg_data
    );

    modport slave (
        input  wr_valid, wr_key, wr_addr, wr_data, mem_ready,
        input  rd_valid, rd_key, rd_addr, rd_data, reg_ready,
        output wr_ready, mem_valid, mem_data,
        output rd_ready, reg_valid, reg_data
    );
endinterface

// File: rtl/secure_xfer_engine.sv
// Key-checked one-entry transfer stages with data transforms and lockout.
// Optional build macro: SECURE_XFER_STATS_EN enables the acc_cnt/rej_cnt
// handshake counters; without it both outputs are tied to zero.
//
// state  | meaning
// -------+-----------------------------------------------------------
// OPEN   | handshakes accepted; bad keys accumulate in the fail count
// LOCKED | both readies low; held outputs drain; timer counts down
module secure_xfer_engine #(
    parameter int               DATA_W      = 32,
    parameter int               ADDR_W      = 10,
    parameter int               KEY_W       = 16,
    parameter logic [KEY_W-1:0] KEY_VAL     = 16'h0032,
    parameter int               ADDR_THRESH = 128,
    parameter int               MAX_FAIL    = 3,
    parameter int               LOCK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    secure_xfer_if.slave bus,
    output logic        locked,
    output logic [1:0]  key_err,
    output logic [15:0] acc_cnt,
    output logic [15:0] rej_cnt
);

    localparam logic [ADDR_W-1:0] THRESH   = ADDR_W'(ADDR_THRESH);
    localparam int                FAIL_W   = $clog2(MAX_FAIL + 1);
    localparam logic [FAIL_W:0]   FAIL_MAX = (FAIL_W + 1)'(MAX_FAIL);
    localparam int                TMR_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(LOCK_CYCLES - 1);

    typedef enum logic {OPEN, LOCKED} state_t;

    state_t            state;
    logic [FAIL_W-1:0] fail_cnt;
    logic [TMR_W-1:0]  lock_tmr;

    logic       wr_fire, rd_fire;
    logic       wr_good, wr_bad, rd_good, rd_bad;
    logic [1:0] n_bad;
    logic [FAIL_W:0] fail_sum, fail_sat;

    function automatic logic [DATA_W-1:0] wr_xform(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] t;
        t = d - DATA_W'(3);
        return (t * t + DATA_W'(9)) * DATA_W'(3);
    endfunction

    function automatic logic [DATA_W-1:0] rd_xform(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] t;
        t = (d / DATA_W'(3)) - DATA_W'(9);
        return ~(t * t + DATA_W'(3));
    endfunction

    // A stage accepts when open and its output slot is empty or draining now.
    assign bus.wr_ready = !locked && (!bus.mem_valid || bus.mem_ready);
    assign bus.rd_ready = !locked && (!bus.reg_valid || bus.reg_ready);

    assign wr_fire = bus.wr_valid && bus.wr_ready;
    assign rd_fire = bus.rd_valid && bus.rd_ready;
    assign wr_good = wr_fire && (bus.wr_key == KEY_VAL);
    assign wr_bad  = wr_fire && (bus.wr_key != KEY_VAL);
    assign rd_good = rd_fire && (bus.rd_key == KEY_VAL);
    assign rd_bad  = rd_fire && (bus.rd_key != KEY_VAL);

    assign n_bad    = {1'b0, wr_bad} + {1'b0, rd_bad};
    assign fail_sum = {1'b0, fail_cnt} + (FAIL_W + 1)'(n_bad);
    assign fail_sat = (fail_sum >= FAIL_MAX) ? FAIL_MAX : fail_sum;

    // Lockout FSM: fail accounting in OPEN, down-counting timer in LOCKED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= OPEN;
            fail_cnt <= '0;
            lock_tmr <= '0;
            locked   <= 1'b0;
        end else begin
            case (state)
                OPEN: begin
                    if (n_bad != 2'd0) begin
                        fail_cnt <= fail_sat[FAIL_W-1:0];
                        if (fail_sat == FAIL_MAX) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            lock_tmr <= TMR_LOAD;
                        end
                    end else if (wr_good || rd_good) begin
                        fail_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (lock_tmr == '0) begin
                        state    <= OPEN;
                        locked   <= 1'b0;
                        fail_cnt <= '0;
                    end else begin
                        lock_tmr <= lock_tmr - 1'b1;
                    end
                end
                default: begin
                    state  <= OPEN;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Write output register: load on good key, otherwise empty when drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_valid <= 1'b0;
            bus.mem_data  <= '0;
        end else if (wr_good) begin
            bus.mem_valid <= 1'b1;
            bus.mem_data  <= (bus.wr_addr > THRESH) ? wr_xform(bus.wr_data) : bus.wr_data;
        end else if (bus.mem_ready) begin
            bus.mem_valid <= 1'b0;
        end
    end

    // Read output register: same policy as the write side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.reg_valid <= 1'b0;
            bus.reg_data  <= '0;
        end else if (rd_good) begin
            bus.reg_valid <= 1'b1;
            bus.reg_data  <= (bus.rd_addr > THRESH) ? rd_xform(bus.rd_data) : bus.rd_data;
        end else if (bus.reg_ready) begin
            bus.reg_valid <= 1'b0;
        end
    end

    // One-cycle bad-key pulse per channel (bit0 write, bit1 read).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_err <= 2'b00;
        else     key_err <= {rd_bad, wr_bad};
    end

`ifdef SECURE_XFER_STATS_EN
    logic [1:0]  n_good;
    logic [16:0] acc_sum, rej_sum;

    assign n_good  = {1'b0, wr_good} + {1'b0, rd_good};
    assign acc_sum = {1'b0, acc_cnt} + 17'(n_good);
    assign rej_sum = {1'b0, rej_cnt} + 17'(n_bad);

    // Saturating handshake statistics, both channels summed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= '0;
            rej_cnt <= '0;
        end else begin
            acc_cnt <= acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
            rej_cnt <= rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
        end
    end
`else
    assign acc_cnt = 16'h0000;
    assign rej_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_secure_xfer_engine.sv
// Directed plus randomized bench for secure_xfer_engine, checked against a
// queue/arithmetic reference model of the transfer and lockout rules.
module tb_secure_xfer_engine;

    localparam logic [15:0] KEY_OK  = 16'h0032;
    localparam logic [15:0] KEY_BAD = 16'h0031;
    localparam int          MAXF    = 3;
    localparam int          LOCKN   = 16;

    logic        clk;
    logic        rst;
    logic        locked;
    logic [1:0]  key_err;
    logic [15:0] acc_cnt;
    logic [15:0] rej_cnt;

    secure_xfer_if #(.DATA_W(32), .ADDR_W(10), .KEY_W(16)) bus ();

    secure_xfer_engine dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .locked  (locked),
        .key_err (key_err),
        .acc_cnt (acc_cnt),
        .rej_cnt (rej_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int mem_xfers   = 0;

    logic [31:0] m_wq[$];
    logic [31:0] m_rq[$];
    int m_fail, m_lock_left, m_acc, m_rej;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_ref(input logic [31:0] d, input logic [9:0] a);
        longint unsigned m, t;
        logic [31:0] r;
        if (a <= 10'd128) return d;
        m = 64'h1_0000_0000;
        t = (64'(d) + m - 3) % m;
        t = (t * t) % m;
        t = ((t + 9) * 3) % m;
        r = t[31:0];
        return r;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] d, input logic [9:0] a);
        longint unsigned m, t;
        logic [31:0] r;
        if (a <= 10'd128) return d;
        m = 64'h1_0000_0000;
        t = 64'(d) / 3;
        t = (t + m - 9) % m;
        t = (t * t) % m;
        t = (t + 3) % m;
        r = t[31:0];
        return ~r;
    endfunction

    task automatic model_reset();
        m_wq.delete();
        m_rq.delete();
        m_fail      = 0;
        m_lock_left = 0;
        m_acc       = 0;
        m_rej       = 0;
    endtask

    // One clock: drive at edge+1, check settled state, advance model, check pulses.
    task automatic cycle(input logic wv, input logic [15:0] wk, input logic [9:0] wa,
                         input logic [31:0] wd, input logic mr,
                         input logic rv, input logic [15:0] rk, input logic [9:0] ra,
                         input logic [31:0] rdat, input logic rr);
        logic ml, ewr, erd, wf, rf, wg, wb, rg, rb;
        int nb, ng;
        bus.wr_valid = wv; bus.wr_key = wk; bus.wr_addr = wa; bus.wr_data = wd;
        bus.mem_ready = mr;
        bus.rd_valid = rv; bus.rd_key = rk; bus.rd_addr = ra; bus.rd_data = rdat;
        bus.reg_ready = rr;
        #1;
        ml  = (m_lock_left > 0);
        ewr = !ml && (m_wq.size() == 0 || mr);
        erd = !ml && (m_rq.size() == 0 || rr);
        check("locked", locked, ml);
        check("wr_ready", bus.wr_ready, ewr);
        check("rd_ready", bus.rd_ready, erd);
        check("mem_valid", bus.mem_valid, m_wq.size() != 0);
        check("reg_valid", bus.reg_valid, m_rq.size() != 0);
        if (m_wq.size() != 0) check("mem_data", bus.mem_data, m_wq[0]);
        if (m_rq.size() != 0) check("reg_data", bus.reg_data, m_rq[0]);
`ifdef SECURE_XFER_STATS_EN
        check("acc_cnt", acc_cnt, m_acc);
        check("rej_cnt", rej_cnt, m_rej);
`else
        check("acc_cnt", acc_cnt, 0);
        check("rej_cnt", rej_cnt, 0);
`endif
        if (bus.mem_valid && mr) mem_xfers++;
        wf = wv && ewr; wg = wf && (wk == KEY_OK); wb = wf && (wk != KEY_OK);
        rf = rv && erd; rg = rf && (rk == KEY_OK); rb = rf && (rk != KEY_OK);
        if (mr && m_wq.size() != 0) void'(m_wq.pop_front());
        if (rr && m_rq.size() != 0) void'(m_rq.pop_front());
        if (wg) m_wq.push_back(wr_ref(wd, wa));
        if (rg) m_rq.push_back(rd_ref(rdat, ra));
        nb = int'(wb) + int'(rb);
        ng = int'(wg) + int'(rg);
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fail = 0;
        end else if (nb > 0) begin
            m_fail = (m_fail + nb > MAXF) ? MAXF : m_fail + nb;
            if (m_fail >= MAXF) m_lock_left = LOCKN;
        end else if (ng > 0) begin
            m_fail = 0;
        end
        m_acc = (m_acc + ng > 65535) ? 65535 : m_acc + ng;
        m_rej = (m_rej + nb > 65535) ? 65535 : m_rej + nb;
        @(posedge clk);
        #1;
        check("key_err", key_err, {rb, wb});
    endtask

    task automatic idle(input logic mr, input logic rr);
        cycle(1'b0, KEY_OK, 10'd0, 32'd0, mr, 1'b0, KEY_OK, 10'd0, 32'd0, rr);
    endtask

    // Reset asserted between edges, released one clock later.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic wv, mr, rv, rr;
        logic [15:0] wk, rk;
        logic [9:0] wa, ra;

        rst = 1'b1;
        bus.wr_valid = 1'b0; bus.wr_key = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.mem_ready = 1'b0;
        bus.rd_valid = 1'b0; bus.rd_key = '0; bus.rd_addr = '0; bus.rd_data = '0;
        bus.reg_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_valid", bus.mem_valid, 0);
        check("rst_reg_valid", bus.reg_valid, 0);
        check("rst_mem_data", bus.mem_data, 0);
        check("rst_reg_data", bus.reg_data, 0);
        check("rst_key_err", key_err, 0);
        check("rst_locked", locked, 0);
        check("rst_acc_cnt", acc_cnt, 0);
        check("rst_rej_cnt", rej_cnt, 0);
        rst = 1'b0;

        // Transformed write, then held by backpressure for 5 clocks.
        cycle(1'b1, KEY_OK, 10'd200, 32'd10, 1'b0, 1'b0, KEY_OK, 10'd0, 32'd0, 1'b1);
        check("wr_xform_valid", bus.mem_valid, 1);
        check("wr_xform_data", bus.mem_data, 174);
        mem_xfers = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, KEY_OK, 10'd300, $urandom, 1'b0, 1'b0, KEY_OK, 10'd0, 32'd0, 1'b1);
            check("hold_mem_data", bus.mem_data, 174);
        end
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b1);
        check("single_xfer", mem_xfers, 1);

        // Threshold address passes straight through.
        cycle(1'b1, KEY_OK, 10'd128, 32'd10, 1'b1, 1'b0, KEY_OK, 10'd0, 32'd0, 1'b1);
        check("wr_thresh_data", bus.mem_data, 10);
        idle(1'b1, 1'b1);

        // Read transform, then simultaneous drain and accept of a passthrough.
        cycle(1'b0, KEY_OK, 10'd0, 32'd0, 1'b1, 1'b1, KEY_OK, 10'd200, 32'd30, 1'b0);
        check("rd_xform_data", bus.reg_data, 32'hFFFF_FFFB);
        cycle(1'b0, KEY_OK, 10'd0, 32'd0, 1'b1, 1'b1, KEY_OK, 10'd5, 32'd30, 1'b1);
        check("rd_pass_valid", bus.reg_valid, 1);
        check("rd_pass_data", bus.reg_data, 30);
        idle(1'b1, 1'b1);

        // Random traffic, including thresholds, backpressure and bad keys.
        for (int i = 0; i < 400; i++) begin
            wv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 3) != 0);
            rr = 1'($urandom_range(0, 3) != 0);
            wk = ($urandom_range(0, 11) == 0) ? KEY_BAD : KEY_OK;
            rk = ($urandom_range(0, 11) == 0) ? KEY_BAD : KEY_OK;
            wa = 10'($urandom_range(120, 136));
            ra = 10'($urandom_range(0, 1023));
            cycle(wv, wk, wa, $urandom, mr, rv, rk, ra, $urandom, rr);
        end
        repeat (LOCKN + 2) idle(1'b1, 1'b1);

        // Three bad write keys lock the engine for exactly LOCKN clocks.
        do_reset();
        repeat (3) cycle(1'b1, KEY_BAD, 10'd200, 32'd7, 1'b1, 1'b0, KEY_OK, 10'd0, 32'd0, 1'b1);
        check("lock_entered", locked, 1);
        check("lock_no_mem_valid", bus.mem_valid, 0);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, KEY_OK, 10'd200, 32'd7, 1'b1, 1'b1, KEY_OK, 10'd200, 32'd7, 1'b1);
            if (locked) n++;
            else break;
        end
        check("lock_length", n, LOCKN);
        cycle(1'b1, KEY_OK, 10'd3, 32'd99, 1'b1, 1'b0, KEY_OK, 10'd0, 32'd0, 1'b1);
        check("reopen_accept", bus.mem_data, 99);
        idle(1'b1, 1'b1);

        // Reset while a result is held discards it asynchronously.
        cycle(1'b1, KEY_OK, 10'd9, 32'd55, 1'b0, 1'b0, KEY_OK, 10'd0, 32'd0, 1'b1);
        check("pre_rst_valid", bus.mem_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", bus.mem_valid, 0);
        check("async_rst_data", bus.mem_data, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) idle(1'b0, 1'b0);

        // Same-cycle bad keys on both channels, then one bad read.
        cycle(1'b1, KEY_BAD, 10'd1, 32'd1, 1'b1, 1'b1, KEY_BAD, 10'd1, 32'd1, 1'b1);
        check("dual_bad_not_locked", locked, 0);
        cycle(1'b0, KEY_OK, 10'd0, 32'd0, 1'b1, 1'b1, KEY_BAD, 10'd1, 32'd1, 1'b1);
        check("dual_bad_locked", locked, 1);
`ifdef SECURE_XFER_STATS_EN
        check("dual_bad_rej_cnt", rej_cnt, 3);
`else
        check("dual_bad_rej_cnt", rej_cnt, 0);
`endif
        repeat (LOCKN + 2) idle(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/secure_xfer_engine.md
SECURE_XFER_ENGINE -- requirements
Module: secure_xfer_engine

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, data width of both channels.
REQ-002 SHALL provide parameter ADDR_W, default 10, address width.
REQ-003 SHALL provide parameter KEY_W, default 16, key width.
REQ-004 SHALL provide parameter KEY_VAL, default 16'h0032, the accepted key.
REQ-005 SHALL provide parameter ADDR_THRESH, default 128, transform applies only when addr > ADDR_THRESH.
REQ-006 SHALL provide parameter MAX_FAIL, default 3, bad-key count that triggers lockout.
REQ-007 SHALL provide parameter LOCK_CYCLES, default 16, lockout duration in clocks.
REQ-008 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-high reset.
REQ-009 SHALL have write-channel inputs (reg->mem): wr_valid 1, wr_key KEY_W, wr_addr ADDR_W, wr_data DATA_W; wr_ready out 1.
REQ-010 SHALL have write-channel outputs: mem_valid out 1, mem_data out DATA_W, mem_ready in 1.
REQ-011 SHALL have read-channel inputs (mem->reg): rd_valid 1, rd_key KEY_W, rd_addr ADDR_W, rd_data DATA_W; rd_ready out 1.
REQ-012 SHALL have read-channel outputs: reg_valid out 1, reg_data out DATA_W, reg_ready in 1.
REQ-013 SHALL have status outputs: locked out 1; key_err out 2 (bit0 write, bit1 read, one-cycle pulse); acc_cnt out 16; rej_cnt out 16.

Function
REQ-014 Each channel SHALL be a one-entry registered stage; handshake fires on valid&&ready; result appears at the output register the next clock.
REQ-015 wr_ready SHALL equal !locked && (!mem_valid || mem_ready); rd_ready likewise with reg_valid/reg_ready.
REQ-016 Output valid SHALL hold, with data stable, until the consumer ready is seen high; simultaneous drain and accept SHALL keep valid high with new data.
REQ-017 Write transform SHALL be mem_data = (((d-3)*(d-3))+9)*3 if wr_addr > ADDR_THRESH, else d; all arithmetic unsigned modulo 2^DATA_W.
REQ-018 Read transform SHALL be reg_data = ~((((d/3)-9)*((d/3)-9))+3) if rd_addr > ADDR_THRESH, else d; integer division truncates; modulo 2^DATA_W.
REQ-019 addr == ADDR_THRESH SHALL pass data through unchanged.
REQ-020 A handshake whose key != KEY_VAL SHALL be consumed and dropped (no output valid), and SHALL pulse the matching key_err bit the next clock.
REQ-021 FSM states SHALL be OPEN and LOCKED; fail counter increments by the number of bad-key handshakes in the cycle (0,1,2), saturating at MAX_FAIL.
REQ-022 Any good-key handshake with no bad key in the same cycle SHALL clear the fail counter.
REQ-023 OPEN->LOCKED SHALL occur when the updated fail count reaches MAX_FAIL; locked=1 from the next clock.
REQ-024 In LOCKED, both ready outputs SHALL be 0; pending output registers SHALL still drain normally.
REQ-025 LOCKED->OPEN SHALL occur after exactly LOCK_CYCLES clocks, clearing the fail counter.

Reset
REQ-026 On rst high, immediately: state OPEN, fail counter 0, mem_valid=0, reg_valid=0, mem_data=0, reg_data=0, key_err=0, locked=0, acc_cnt=0, rej_cnt=0.
REQ-027 Reset mid-transfer SHALL discard held outputs; no output valid SHALL appear after release without a new handshake.

Configuration
REQ-028 Macro SECURE_XFER_STATS_EN defined: acc_cnt counts good-key handshakes, rej_cnt counts bad-key handshakes, both channels summed, each saturating at 16'hFFFF.
REQ-029 Macro not defined: acc_cnt and rej_cnt SHALL be constant 0 and counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Write key 0x0032, addr 200, data 10 -> mem_valid next clock, mem_data=174; addr 128, data 10 -> mem_data=10.
REQ-031 Read key 0x0032, addr 200, data 30 -> reg_data=32'hFFFFFFFB; addr 5, data 30 -> reg_data=30.
REQ-032 mem_ready held 0 for 5 clocks after a valid result -> mem_data stable, wr_ready=0, no loss; release -> single transfer.
REQ-033 Three write handshakes with key 0x0031 -> key_err[0] pulses x3, no mem_valid, locked=1 for exactly 16 clocks, both readies 0, then OPEN.
REQ-034 Same-cycle bad write key and bad read key, then one bad read -> lockout after second cycle; with SECURE_XFER_STATS_EN, rej_cnt=3.
REQ-035 rst asserted while mem_valid=1 -> mem_valid=0 asynchronously; after release mem_valid stays 0 until a new handshake.
